// File: rtl/mem_2rw_sync_mask_write_byte_synth.sv
// True dual-port synchronous SRAM with per-byte write masks and one-cycle registered read data.
// Define MEM_2RW_CLKGATE_EN to clock the array and output registers through a latch-based gate.
module mem_2rw_sync_mask_write_byte_synth #(
   parameter int width_p                = 64,
   parameter int els_p                  = 512,
   parameter int read_write_same_addr_p = 0,
   parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int write_mask_width_lp    = width_p / 8
) (
   input  logic                           clk_i,
   input  logic                           reset_i,

   input  logic [width_p-1:0]             a_data_i,
   input  logic [write_mask_width_lp-1:0] a_w_mask_i,
   input  logic [addr_width_lp-1:0]       a_addr_i,
   input  logic                           a_v_i,
   input  logic                           a_w_i,

   input  logic [width_p-1:0]             b_data_i,
   input  logic [write_mask_width_lp-1:0] b_w_mask_i,
   input  logic [addr_width_lp-1:0]       b_addr_i,
   input  logic                           b_v_i,
   input  logic                           b_w_i,

   output logic [width_p-1:0]             a_data_o,
   output logic [width_p-1:0]             b_data_o
);

   localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

   logic               clk_mem;
   logic               a_in_range, b_in_range;
   logic               a_we, b_we;
   logic               a_re, b_re;
   logic [width_p-1:0] a_bit_mask, b_bit_mask;
   logic [width_p-1:0] a_mem_word, b_mem_word;
   logic [width_p-1:0] a_rd_word, b_rd_word;
   logic [width_p-1:0] mem [els_p];

`ifdef MEM_2RW_CLKGATE_EN
   logic gate_en;

   // NOTE: this latch is intentional; holding the enable while clk_i is high keeps clk_mem glitch-free.
   always_latch begin
      if (!clk_i) gate_en <= a_v_i | b_v_i;
   end

   assign clk_mem = clk_i & gate_en;
`else
   assign clk_mem = clk_i;
`endif

   assign a_in_range = ({1'b0, a_addr_i} < els_lp);
   assign b_in_range = ({1'b0, b_addr_i} < els_lp);

   assign a_we = a_v_i &  a_w_i & a_in_range & ~reset_i;
   assign b_we = b_v_i &  b_w_i & b_in_range & ~reset_i;
   assign a_re = a_v_i & ~a_w_i;
   assign b_re = b_v_i & ~b_w_i;

   for (genvar i = 0; i < write_mask_width_lp; i++) begin : g_lane
      assign a_bit_mask[8*i +: 8] = {8{a_w_mask_i[i]}};
      assign b_bit_mask[8*i +: 8] = {8{b_w_mask_i[i]}};
   end

   // Port B is applied last so it owns any byte lane both ports write to the same word.
   // NOTE: the array is deliberately left without a reset so it maps onto RAM and keeps contents across reset_i.
   always_ff @(posedge clk_mem) begin
      for (int i = 0; i < write_mask_width_lp; i++) begin
         // NOTE: non-blocking writes make every read this edge see the pre-write word.
         if (a_we && a_w_mask_i[i]) mem[a_addr_i][8*i +: 8] <= a_data_i[8*i +: 8];
         if (b_we && b_w_mask_i[i]) mem[b_addr_i][8*i +: 8] <= b_data_i[8*i +: 8];
      end
   end

   always_comb begin
      a_mem_word = '0;
      b_mem_word = '0;
      if (a_in_range) a_mem_word = mem[a_addr_i];
      if (b_in_range) b_mem_word = mem[b_addr_i];

      a_rd_word = a_mem_word;
      b_rd_word = b_mem_word;
      if (read_write_same_addr_p != 0) begin
         if (b_we && (b_addr_i == a_addr_i))
            a_rd_word = (a_mem_word & ~b_bit_mask) | (b_data_i & b_bit_mask);
         if (a_we && (a_addr_i == b_addr_i))
            b_rd_word = (b_mem_word & ~a_bit_mask) | (a_data_i & a_bit_mask);
      end
   end

   always_ff @(posedge clk_mem or posedge reset_i) begin
      if (reset_i) begin
         a_data_o <= '0;
         b_data_o <= '0;
      end else begin
         if (a_re) a_data_o <= a_rd_word;
         if (b_re) b_data_o <= b_rd_word;
      end
   end

endmodule

// File: tb/tb_mem_2rw_sync_mask_write_byte_synth.sv
// Directed bench for the dual-port byte-masked SRAM: a 64x512 read-old instance
// and a 16-bit, 12-word write-through instance for collision and range corners.
module tb_mem_2rw_sync_mask_write_byte_synth;

   typedef enum logic [1:0] {IDLE, RD, WR, IW} op_t;

   typedef struct {
      string       name;
      op_t         a_op;
      logic [8:0]  a_addr;
      logic [7:0]  a_mask;
      logic [63:0] a_data;
      op_t         b_op;
      logic [8:0]  b_addr;
      logic [7:0]  b_mask;
      logic [63:0] b_data;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [63:0] a_data, b_data, a_q, b_q;
   logic [7:0]  a_mask, b_mask;
   logic [8:0]  a_addr, b_addr;
   logic        a_v, a_w, b_v, b_w;

   logic [15:0] c_data, d_data, c_q, d_q;
   logic [1:0]  c_mask, d_mask;
   logic [3:0]  c_addr, d_addr;
   logic        c_v, c_w, d_v, d_w;

   int checks = 0;
   int errors = 0;

   mem_2rw_sync_mask_write_byte_synth #(
      .width_p(64), .els_p(512), .read_write_same_addr_p(0)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .a_data_i(a_data), .a_w_mask_i(a_mask), .a_addr_i(a_addr), .a_v_i(a_v), .a_w_i(a_w),
      .b_data_i(b_data), .b_w_mask_i(b_mask), .b_addr_i(b_addr), .b_v_i(b_v), .b_w_i(b_w),
      .a_data_o(a_q), .b_data_o(b_q)
   );

   mem_2rw_sync_mask_write_byte_synth #(
      .width_p(16), .els_p(12), .read_write_same_addr_p(1)
   ) dut_wt (
      .clk_i(clk), .reset_i(rst),
      .a_data_i(c_data), .a_w_mask_i(c_mask), .a_addr_i(c_addr), .a_v_i(c_v), .a_w_i(c_w),
      .b_data_i(d_data), .b_w_mask_i(d_mask), .b_addr_i(d_addr), .b_v_i(d_v), .b_w_i(d_w),
      .a_data_o(c_q), .b_data_o(d_q)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [7:0] mask);
      merge = old;
      for (int i = 0; i < 8; i++) if (mask[i]) merge[8*i +: 8] = nw[8*i +: 8];
   endfunction

   function automatic vec_t mk(input string n,
                               input op_t ao, input logic [8:0] aa, input logic [7:0] am, input logic [63:0] ad,
                               input op_t bo, input logic [8:0] ba, input logic [7:0] bm, input logic [63:0] bd,
                               input logic [63:0] ea, input logic [63:0] eb);
      vec_t v;
      v.name = n;
      v.a_op = ao; v.a_addr = aa; v.a_mask = am; v.a_data = ad;
      v.b_op = bo; v.b_addr = ba; v.b_mask = bm; v.b_data = bd;
      v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic drive_ab(input op_t ao, input logic [8:0] aa, input logic [7:0] am, input logic [63:0] ad,
                           input op_t bo, input logic [8:0] ba, input logic [7:0] bm, input logic [63:0] bd);
      a_v = (ao == RD) || (ao == WR);
      a_w = (ao == WR) || (ao == IW);
      a_addr = aa; a_mask = am; a_data = ad;
      b_v = (bo == RD) || (bo == WR);
      b_w = (bo == WR) || (bo == IW);
      b_addr = ba; b_mask = bm; b_data = bd;
   endtask

   task automatic cyc_cd(input op_t co, input logic [3:0] ca, input logic [1:0] cm, input logic [15:0] cd,
                         input op_t dop, input logic [3:0] da, input logic [1:0] dm, input logic [15:0] dd);
      c_v = (co == RD) || (co == WR);
      c_w = (co == WR);
      c_addr = ca; c_mask = cm; c_data = cd;
      d_v = (dop == RD) || (dop == WR);
      d_w = (dop == WR);
      d_addr = da; d_mask = dm; d_data = dd;
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [63:0] k3     = 64'h1122_3344_5566_7788;
   localparam logic [63:0] ones   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] half   = 64'hFFFF_FFFF_0000_0000;
   localparam logic [63:0] ww_res = 64'h1111_1111_2222_2222;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary line");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[$];
      logic [63:0] model [2];
      logic [63:0] rd_exp, wdata;
      logic [7:0]  wmask;
      int          raddr;

      rst = 1'b1;
      drive_ab(IDLE, 0, 0, 0, IDLE, 0, 0, 0);
      c_v = 0; c_w = 0; c_addr = 0; c_mask = 0; c_data = 0;
      d_v = 0; d_w = 0; d_addr = 0; d_mask = 0; d_data = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset a_data_o", a_q, 64'h0);
      check("reset b_data_o", b_q, 64'h0);
      check("reset wt a_data_o", {48'h0, c_q}, 64'h0);
      check("reset wt b_data_o", {48'h0, d_q}, 64'h0);

      vecs.push_back(mk("wr3_wr5",      WR,   3, 8'hFF, k3,    WR,   5, 8'hFF, ones,  64'h0, 64'h0));
      vecs.push_back(mk("rd3_rd5",      RD,   3, 8'h00, 0,     RD,   5, 8'h00, 0,     k3,    ones));
      vecs.push_back(mk("b_mask_0f",    IDLE, 0, 8'h00, 0,     WR,   5, 8'h0F, 64'h0, k3,    ones));
      vecs.push_back(mk("rd5_masked",   RD,   5, 8'h00, 0,     IDLE, 0, 8'h00, 0,     half,  ones));
      vecs.push_back(mk("wr7",          WR,   7, 8'hFF, 64'hAB, IDLE, 0, 8'h00, 0,    half,  ones));
      vecs.push_back(mk("rd7",          RD,   7, 8'h00, 0,     IDLE, 0, 8'h00, 0,     64'hAB, ones));
      vecs.push_back(mk("hold1",        IDLE, 0, 8'h00, 0,     IDLE, 0, 8'h00, 0,     64'hAB, ones));
      vecs.push_back(mk("hold2",        IDLE, 9, 8'hFF, ones,  IDLE, 9, 8'hFF, ones,  64'hAB, ones));
      vecs.push_back(mk("hold3",        IDLE, 0, 8'h00, 0,     IDLE, 0, 8'h00, 0,     64'hAB, ones));
      vecs.push_back(mk("wr9_zero",     WR,   9, 8'hFF, 64'h0, IDLE, 0, 8'h00, 0,     64'hAB, ones));
      vecs.push_back(mk("coll_old",     WR,   9, 8'h01, 64'h5A, RD,  9, 8'h00, 0,     64'hAB, 64'h0));
      vecs.push_back(mk("coll_after",   IDLE, 0, 8'h00, 0,     RD,   9, 8'h00, 0,     64'hAB, 64'h5A));
      vecs.push_back(mk("ww_same",      WR,   2, 8'hFF, 64'h1111_1111_1111_1111,
                                        WR,   2, 8'h0F, 64'h2222_2222_2222_2222, 64'hAB, 64'h5A));
      vecs.push_back(mk("rd2_both",     RD,   2, 8'h00, 0,     RD,   2, 8'h00, 0,     ww_res, ww_res));
      vecs.push_back(mk("mask_zero",    WR,   3, 8'h00, 64'h0, IDLE, 0, 8'h00, 0,     ww_res, ww_res));
      vecs.push_back(mk("rd3_nop",      RD,   3, 8'h00, 0,     IDLE, 0, 8'h00, 0,     k3,    ww_res));
      vecs.push_back(mk("inv_write",    IW,   3, 8'hFF, 64'h0, IDLE, 0, 8'h00, 0,     k3,    ww_res));
      vecs.push_back(mk("rd7_rd3",      RD,   7, 8'h00, 0,     RD,   3, 8'h00, 0,     64'hAB, k3));

      foreach (vecs[i]) begin
         drive_ab(vecs[i].a_op, vecs[i].a_addr, vecs[i].a_mask, vecs[i].a_data,
                  vecs[i].b_op, vecs[i].b_addr, vecs[i].b_mask, vecs[i].b_data);
         @(posedge clk);
         @(negedge clk);
         check({vecs[i].name, " a"}, a_q, vecs[i].exp_a);
         check({vecs[i].name, " b"}, b_q, vecs[i].exp_b);
      end

      // Mid-cycle reset clears outputs at once; accesses under reset are ignored.
      drive_ab(IDLE, 0, 0, 0, IDLE, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("async reset a", a_q, 64'h0);
      check("async reset b", b_q, 64'h0);
      drive_ab(WR, 3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, RD, 3, 8'h00, 0);
      @(posedge clk);
      @(negedge clk);
      check("in reset a", a_q, 64'h0);
      check("in reset b", b_q, 64'h0);
      rst = 1'b0;
      drive_ab(RD, 3, 8'h00, 0, IDLE, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      check("preserved mem3", a_q, k3);
      check("post reset b", b_q, 64'h0);

      // Concurrent traffic: A reads while B writes addr 1 with random data and masks.
      model[0] = 64'h0123_4567_89AB_CDEF;
      model[1] = 64'hFEDC_BA98_7654_3210;
      drive_ab(WR, 0, 8'hFF, model[0], WR, 1, 8'hFF, model[1]);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         raddr  = (i < 50) ? 0 : int'($urandom_range(0, 1));
         wdata  = {$urandom, $urandom};
         wmask  = 8'($urandom_range(0, 255));
         rd_exp = model[raddr];
         drive_ab(RD, 9'(raddr), 8'h00, 0, WR, 1, wmask, wdata);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rand%0d a", i), a_q, rd_exp);
         model[1] = merge(model[1], wdata, wmask);
      end
      drive_ab(RD, 1, 8'h00, 0, IDLE, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      check("rand final mem1", a_q, model[1]);
      drive_ab(IDLE, 0, 0, 0, IDLE, 0, 0, 0);

      // Write-through instance: collision reads see the merged new word.
      cyc_cd(WR, 9, 2'b11, 16'h0000, IDLE, 0, 2'b00, 16'h0);
      cyc_cd(WR, 9, 2'b01, 16'h005A, RD,   9, 2'b00, 16'h0);
      check("wt low lane", {48'h0, d_q}, 64'h005A);
      cyc_cd(WR, 9, 2'b10, 16'h7700, RD,   9, 2'b00, 16'h0);
      check("wt merge", {48'h0, d_q}, 64'h775A);
      cyc_cd(RD, 9, 2'b00, 16'h0,    IDLE, 0, 2'b00, 16'h0);
      check("wt stored", {48'h0, c_q}, 64'h775A);
      cyc_cd(WR, 2, 2'b11, 16'h1111, WR,   2, 2'b01, 16'h2222);
      cyc_cd(RD, 2, 2'b00, 16'h0,    IDLE, 0, 2'b00, 16'h0);
      check("ww b wins", {48'h0, c_q}, 64'h1122);
      cyc_cd(RD, 2, 2'b00, 16'h0,    WR,   2, 2'b10, 16'hAB00);
      check("wt from b", {48'h0, c_q}, 64'hAB22);
      cyc_cd(WR, 11, 2'b11, 16'h0BAD, WR,  12, 2'b11, 16'hBEEF);
      cyc_cd(RD, 11, 2'b00, 16'h0,    RD,  12, 2'b00, 16'h0);
      check("last word", {48'h0, c_q}, 64'h0BAD);
      check("oor read 12", {48'h0, d_q}, 64'h0);
      cyc_cd(RD, 15, 2'b00, 16'h0,    RD,  11, 2'b00, 16'h0);
      check("oor read 15", {48'h0, c_q}, 64'h0);
      check("last word b", {48'h0, d_q}, 64'h0BAD);
      cyc_cd(IDLE, 0, 2'b00, 16'h0,   IDLE, 0, 2'b00, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_2rw_sync_mask_write_byte_synth.md
Name: mem_2rw_sync_mask_write_byte_synth

Overview:
- True dual-port synchronous SRAM model with two independent read/write ports (A, B), per-byte write masks and one-cycle registered read data.
- Behavioural/synthesizable core under the BSG memory wrappers. It is used wherever two agents, such as a cache fill path and a CPU port, need concurrent byte-granular access to one array.
- Includes an optional clock-gating front end equivalent to bsg_clkgate_optional, enabled when either port is active.

Parameters:
- width_p, 64, data width in bits; must be a multiple of 8 and at least 8.
- els_p, 512, number of words.
- read_write_same_addr_p, 0, same-address read/write policy across ports (see Behaviour).
- addr_width_lp, max(1, clog2(els_p)), derived address width.
- write_mask_width_lp, width_p/8, derived byte-mask width.

Ports:
- clk_i  in  1  clock; rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- a_data_i  in  width_p  port A write data.
- a_w_mask_i  in  write_mask_width_lp  port A byte enables; bit i covers data bits [8i+7:8i].
- a_addr_i  in  addr_width_lp  port A word address.
- a_v_i  in  1  port A access valid.
- a_w_i  in  1  port A write (1) or read (0); meaningful only when a_v_i=1.
- b_data_i, b_w_mask_i, b_addr_i, b_v_i, b_w_i  in  same widths  port B, same meanings as port A.
- a_data_o  out  width_p  port A registered read data.
- b_data_o  out  width_p  port B registered read data.

Behaviour:
- Reset:
  - reset_i=1 asynchronously clears a_data_o and b_data_o to 0.
  - While reset_i is high, all accesses are ignored: no writes, no reads.
  - Array contents are not reset; they hold across reset.
- Write, port X:
  - On a rising edge with X_v_i=1, X_w_i=1 and X_addr_i<els_p, each byte i with X_w_mask_i[i]=1 is written from X_data_i.
  - Unmasked bytes are preserved.
  - A write with an all-zero mask is a legal no-op.
- Read, port X:
  - On a rising edge with X_v_i=1, X_w_i=0, X_data_o loads mem[X_addr_i].
  - Latency is exactly 1 cycle.
  - X_data_o holds its value on idle cycles (X_v_i=0) and on write cycles of the same port.
- Out-of-range address (addr >= els_p):
  - Writes are dropped.
  - Reads load 0.
- Ports are fully independent. Both may read, both may write, or one may read while the other writes, in the same cycle.
- Cross-port read/write, same address, same cycle:
  - read_write_same_addr_p=0: the reader returns the old (pre-write) word.
  - read_write_same_addr_p=1: the reader returns the new word, i.e. written bytes from the writer merged with old unmasked bytes (write-through).
- Write/write, same address, same cycle:
  - Byte lanes enabled by only one port take that port's data.
  - Lanes enabled by both ports take port B's data (B wins).
- Both ports reading the same address: both return the same word.
- Clock-gated operation, when compiled in: the array and output registers clock only on cycles with a_v_i|b_v_i=1. The gate enable is latched while clk_i is low so there are no glitches. Observable behaviour is identical to the ungated build.

Optional Feature:
- Macro MEM_2RW_CLKGATE_EN.
- Defined: an internal latch-based clock gate (enable latched on clk_i low, gated clock = clk_i & latched enable, with enable = a_v_i|b_v_i) drives the array and output registers. Asynchronous reset still clears the outputs without a clock.
- Undefined: the array and output registers run directly on clk_i.
- Port-level, cycle-level results are identical in both builds.

Test Plan:
- Reset and hold:
  - Stimulus: assert reset_i mid-cycle after loading outputs with nonzero data.
  - Required: a_data_o and b_data_o = 0 immediately, before any clock edge.
  - Stimulus: write mem[3]=0x1122334455667788, then deassert reset_i and read addr 3.
  - Required: contents preserved, returns 0x1122334455667788.
- Byte mask:
  - Stimulus: A writes 0xFFFF_FFFF_FFFF_FFFF to addr 5 with mask 0xFF. Next cycle B writes 0x0 with mask 0x0F. Then A reads addr 5.
  - Required: a_data_o = 0xFFFFFFFF00000000 one cycle after the read.
- Latency and hold:
  - Stimulus: A reads addr 7 (value 0xAB) with a_v_i=1, then a_v_i=0 for 3 cycles.
  - Required: a_data_o = 0xAB from the cycle after the read and stays 0xAB throughout.
- Cross-port collision:
  - Stimulus: mem[9]=0x00 (width 8); same cycle A writes 0x5A to addr 9 with mask 1 while B reads addr 9.
  - Required: b_data_o = 0x00 with read_write_same_addr_p=0; b_data_o = 0x5A with read_write_same_addr_p=1.
- Write/write same address (width 16):
  - Stimulus: A writes 0x1111 with mask 2'b11, B writes 0x2222 with mask 2'b01, both to addr 2 in the same cycle; then read addr 2.
  - Required: read returns 0x1122.
- Concurrent independent ports:
  - Stimulus: A reads addr 0 while B writes addr 1 for 100 random cycles.
  - Required: results match a reference model; repeat with MEM_2RW_CLKGATE_EN defined and get identical traces.
